// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - filtered, cause-recording, ordered multi-stage reset release
// Filters the button and clock-lock inputs, then releases each reset stage in turn with a fixed gap.
module reset_sequencer #(
    parameter int NUM_STAGES  = 3,
    parameter int FILTER_BITS = 22,
    parameter int STAGE_GAP   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  btnRst,
    input  logic                  mmcmLocked,
    input  logic                  swRstReq,
    output logic [NUM_STAGES-1:0] rstOut,
    output logic                  rstDone,
    output logic [3:0]            rstCause
);

    localparam int SIDX_W = $clog2(NUM_STAGES + 1);
    localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_FILTER  = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [SYNC_STAGES-1:0]   r_btn_sync;
    logic [SYNC_STAGES-1:0]   r_lock_sync;
    logic [SYNC_STAGES-1:0]   r_settle;
    logic [FILTER_BITS-1:0]   r_filt_cnt;
    logic [FILTER_BITS-1:0]   w_filt_next;
    logic [GAP_W-1:0]         r_gap_cnt;
    logic [GAP_W-1:0]         w_gap_next;
    logic [SIDX_W-1:0]        r_stage_idx;
    logic [SIDX_W-1:0]        w_stage_next;
    logic [NUM_STAGES-1:0]    r_rst_out;
    logic [NUM_STAGES-1:0]    w_rst_next;
    logic                     r_done;
    logic                     w_done_next;
    logic [3:0]               r_cause;
    logic [3:0]               w_cause_next;

    logic                     w_btn_s;
    logic                     w_lock_s;
    logic                     w_settled;
    logic                     w_event;
    logic [3:0]               w_ev_bits;
    logic                     w_filt_done;
    logic                     w_gap_done;
    logic                     w_last_stage;

    assign w_btn_s   = r_btn_sync[SYNC_STAGES-1];
    assign w_lock_s  = r_lock_sync[SYNC_STAGES-1];
    assign w_settled = r_settle[SYNC_STAGES-1];
    assign w_event   = w_btn_s | ~w_lock_s | swRstReq;

    // Until the synchronizers have flushed their reset values, btn/lock still hold
    // the sequencer in HOLD but are not blamed as the cause of the reset.
    assign w_ev_bits = {swRstReq, ~w_lock_s & w_settled, w_btn_s & w_settled, 1'b0};

    assign w_filt_done  = &r_filt_cnt;
    assign w_gap_done   = (r_gap_cnt == GAP_W'(STAGE_GAP - 1));
    assign w_last_stage = (r_stage_idx == SIDX_W'(NUM_STAGES - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_HOLD;
            r_btn_sync  <= '1;
            r_lock_sync <= '0;
            r_settle    <= '0;
            r_filt_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_stage_idx <= '0;
            r_rst_out   <= '1;
            r_done      <= 1'b0;
            r_cause     <= 4'b0001;
        end else begin
            r_state     <= w_state_next;
            r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], btnRst};
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], mmcmLocked};
            r_settle    <= {r_settle[SYNC_STAGES-2:0], 1'b1};
            r_filt_cnt  <= w_filt_next;
            r_gap_cnt   <= w_gap_next;
            r_stage_idx <= w_stage_next;
            r_rst_out   <= w_rst_next;
            r_done      <= w_done_next;
            r_cause     <= w_cause_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_event) begin
            w_state_next = S_HOLD;
        end else begin
            case (r_state)
                S_HOLD:    w_state_next = S_FILTER;
                S_FILTER:  if (w_filt_done) w_state_next = (NUM_STAGES == 1) ? S_RUN : S_RELEASE;
                S_RELEASE: if (w_gap_done && w_last_stage) w_state_next = S_RUN;
                default:   w_state_next = r_state;
            endcase
        end
    end

    always_comb begin
        w_filt_next  = r_filt_cnt;
        w_gap_next   = r_gap_cnt;
        w_stage_next = r_stage_idx;
        w_rst_next   = r_rst_out;
        w_done_next  = r_done;
        if (w_event) begin
            w_filt_next  = '0;
            w_gap_next   = '0;
            w_stage_next = '0;
            w_rst_next   = '1;
            w_done_next  = 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    w_filt_next = '0;
                    w_rst_next  = '1;
                    w_done_next = 1'b0;
                end
                S_FILTER: begin
                    if (w_filt_done) begin
                        w_rst_next[0] = 1'b0;
                        w_gap_next    = '0;
                        w_stage_next  = SIDX_W'(1);
                        w_done_next   = (NUM_STAGES == 1);
                    end else begin
                        w_filt_next = r_filt_cnt + FILTER_BITS'(1);
                    end
                end
                S_RELEASE: begin
                    // Gap counts up to STAGE_GAP-1; the terminal edge releases the next stage.
                    if (w_gap_done) begin
                        w_rst_next   = r_rst_out & ~(NUM_STAGES'(1) << r_stage_idx);
                        w_gap_next   = '0;
                        w_stage_next = r_stage_idx + SIDX_W'(1);
                        w_done_next  = w_last_stage;
                    end else begin
                        w_gap_next = r_gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    w_rst_next = r_rst_out;
                end
            endcase
        end
    end

    always_comb begin
        w_cause_next = r_cause;
        if (r_state == S_HOLD) begin
            w_cause_next = r_cause | w_ev_bits;
        end else if (w_event) begin
            w_cause_next = w_ev_bits;
        end
    end

    assign rstOut   = r_rst_out;
    assign rstDone  = r_done;
    assign rstCause = r_cause;

endmodule
